// File: rtl/lsu_master.sv
// Memory-stage load/store initiator: turns lw/lh/lhu/lb/lbu/sw/sh/sb into word-aligned
// req/ack transactions on the data port; sub-word stores use read-modify-write.
module lsu_master #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              op_valid,
    input  logic [2:0]        op_type,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              align_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       mem_pc,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    state_t      state;
    op_t         op_in;
    op_t         op_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        misaligned;
    logic        is_load_q;

    assign op_in     = op_t'(op_type);
    assign is_load_q = op_q inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};

    always_comb begin
        case (op_in)
            OP_LW, OP_SW:         misaligned = |op_addr[1:0];
            OP_LH, OP_LHU, OP_SH: misaligned = op_addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    always_comb begin
        stall     = !reset && op_valid && !misaligned && (state != DONE);
        align_err = !reset && op_valid && misaligned && (state == IDLE);
    end

    // Lane select and sign/zero extension of a fetched word.
    function automatic logic [31:0] load_ext(input op_t op, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'h0000, h};
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'h000000, b};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input op_t op, input logic [1:0] off,
                                          input logic [31:0] old, input logic [31:0] data);
        logic [31:0] w;
        w = old;
        if (op == OP_SB) begin
            w[{off, 3'b000} +: 8] = data[7:0];
        end else if (off[1]) begin
            w[31:16] = data[15:0];
        end else begin
            w[15:0] = data[15:0];
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_pc      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            op_q        <= OP_LW;
            off_q       <= '0;
            wdata_q     <= '0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && !misaligned) begin
                        op_q     <= op_in;
                        off_q    <= op_addr[1:0];
                        wdata_q  <= op_wdata;
                        mem_pc   <= pc;
                        mem_addr <= {op_addr[ADDR_W-1:2], 2'b00};
                        mem_req  <= 1'b1;
                        if (op_in == OP_SW) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= op_wdata;
                            state     <= WR;
                        end else begin
                            mem_we <= 1'b0;
                            state  <= RD;
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        if (is_load_q) begin
                            rdata       <= load_ext(op_q, off_q, mem_rdata);
                            rdata_valid <= 1'b1;
                            mem_req     <= 1'b0;
                            state       <= DONE;
                        end else begin
                            // RMW: request stays up, turning straight into the write.
                            mem_we    <= 1'b1;
                            mem_wdata <= merge(op_q, off_q, mem_rdata, wdata_q);
                            state     <= WR;
                        end
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_master.sv
// Randomized bench for lsu_master: word-memory responder with random ack delay and a
// transaction-level model of the expected requests, stalls and load results.
module tb_lsu_master;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   pc = '0;
    logic          op_valid = 1'b0;
    logic [2:0]    op_type = '0;
    logic [AW-1:0] op_addr = '0;
    logic [31:0]   op_wdata = '0;
    logic          stall, rdata_valid, align_err, mem_req, mem_we;
    logic [31:0]   rdata, mem_wdata, mem_pc;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    lsu_master #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .op_valid(op_valid), .op_type(op_type),
        .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .align_err(align_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem [256];
    int fixed_wait = 0;
    int wait_cnt = 0;
    bit rst_prev = 1'b1;

    function automatic int pick_wait();
        return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
    endfunction

    always @(posedge clk) begin
        rst_prev = reset;
        if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] = mem_wdata;
        if (reset || !mem_req || mem_ack) wait_cnt = pick_wait();
        #1;
        if (mem_req) begin
            mem_ack = (wait_cnt == 0);
            if (wait_cnt > 0) wait_cnt--;
            mem_rdata = (mem_ack && !mem_we) ? mem[mem_addr[9:2]] : $urandom;
        end else begin
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } txn_t;

    txn_t        txq[$];
    bit          inflight = 0, done_cyc = 0, exp_load = 0, exp_store = 0;
    logic [31:0] exp_rdata = '0, hold_rdata = '0, exp_word = '0, exp_pc = '0;
    logic [7:0]  exp_idx = '0;

    function automatic bit is_mis(input logic [2:0] t, input logic [AW-1:0] a);
        case (t)
            3'd0, 3'd5:       return a[1:0] != 2'b00;
            3'd1, 3'd2, 3'd6: return a[0];
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] t, input logic [AW-1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a[1:0]));
        h = 16'(w >> (16 * a[1]));
        case (t)
            3'd1:    return int'($signed(h));
            3'd2:    return 32'(h);
            3'd3:    return int'($signed(b));
            3'd4:    return 32'(b);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_val(input logic [2:0] t, input logic [AW-1:0] a,
                                              input logic [31:0] old, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (t == 3'd7) begin
            sh   = 8 * a[1:0];
            mask = 32'h0000_00FF << sh;
        end else begin
            sh   = 16 * a[1];
            mask = 32'h0000_FFFF << sh;
        end
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic accept();
        logic [AW-1:0] base;
        logic [31:0]   w;
        base    = op_addr & ~AW'(3);
        exp_idx = op_addr[9:2];
        w       = mem[exp_idx];
        exp_pc  = pc;
        txq.delete();
        exp_load  = (op_type <= 3'd4);
        exp_store = !exp_load;
        if (exp_load) begin
            exp_rdata = load_val(op_type, op_addr, w);
            txq.push_back('{1'b0, base, 32'h0});
        end else if (op_type == 3'd5) begin
            exp_word = op_wdata;
            txq.push_back('{1'b1, base, op_wdata});
        end else begin
            exp_word = store_val(op_type, op_addr, w, op_wdata);
            txq.push_back('{1'b0, base, 32'h0});
            txq.push_back('{1'b1, base, exp_word});
        end
        inflight = 1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_stall", stall, 0);
            chk("rst_align_err", align_err, 0);
            if (rst_prev) begin
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_mem_pc", mem_pc, 0);
                chk("rst_rdata", rdata, 0);
                chk("rst_rdata_valid", rdata_valid, 0);
            end
            inflight = 0;
            done_cyc = 0;
            txq.delete();
            hold_rdata = '0;
        end else if (done_cyc) begin
            if (exp_load) hold_rdata = exp_rdata;
            chk("done_stall", stall, 0);
            chk("done_align_err", align_err, 0);
            chk("done_rdata_valid", rdata_valid, exp_load);
            chk("done_mem_req", mem_req, 0);
            chk("done_rdata", rdata, hold_rdata);
            if (exp_store) chk("done_mem_word", mem[exp_idx], exp_word);
            done_cyc = 0;
            inflight = 0;
        end else if (inflight) begin
            chk("busy_stall", stall, 1);
            chk("busy_align_err", align_err, 0);
            chk("busy_rdata_valid", rdata_valid, 0);
            chk("busy_mem_req", mem_req, 1);
            chk("busy_rdata_hold", rdata, hold_rdata);
            if (txq.size() > 0) begin
                chk("txn_we", mem_we, txq[0].we);
                chk("txn_addr", mem_addr, txq[0].addr);
                if (txq[0].we) chk("txn_wdata", mem_wdata, txq[0].wdata);
                chk("txn_pc", mem_pc, exp_pc);
                if (mem_ack) begin
                    void'(txq.pop_front());
                    if (txq.size() == 0) done_cyc = 1;
                end
            end
        end else begin
            chk("idle_mem_req", mem_req, 0);
            chk("idle_rdata_valid", rdata_valid, 0);
            chk("idle_rdata_hold", rdata, hold_rdata);
            if (op_valid) begin
                chk("idle_align_err", align_err, is_mis(op_type, op_addr));
                chk("idle_stall", stall, !is_mis(op_type, op_addr));
                if (!is_mis(op_type, op_addr)) accept();
            end else begin
                chk("idle_stall_noop", stall, 0);
                chk("idle_align_noop", align_err, 0);
            end
        end
    end

    // ---------------- driver ----------------
    int st, rq, ae;
    logic [2:0]  sub_t [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
    logic [13:0] sub_a [4] = '{14'h13, 14'h13, 14'h12, 14'h12};
    logic [31:0] sub_e [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};

    task automatic run_op(input logic [2:0] t, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [31:0] p, output int s, output int r, output int e);
        bit fin;
        fin = 0;
        s = 0;
        r = 0;
        e = 0;
        op_type  = t;
        op_addr  = a;
        op_wdata = d;
        pc       = p;
        op_valid = 1'b1;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            if (mem_req) r++;
            if (align_err) e++;
            if (stall) s++;
            else fin = 1;
        end
        chk("op_completes", fin, 1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    initial begin
        logic [2:0]    t;
        logic [AW-1:0] a;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        fixed_wait = 0;
        mem[4] = 32'hDEADBEEF;
        run_op(3'd0, 14'h0010, 32'h0, 32'h0000_0100, st, rq, ae);
        chk("lw_stall_cycles", st, 2);
        chk("lw_req_cycles", rq, 1);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_mem_addr", mem_addr, 14'h0010);

        mem[4] = 32'h80FF7F01;
        for (int i = 0; i < 4; i++) begin
            run_op(sub_t[i], sub_a[i], 32'h0, 32'h0000_0200, st, rq, ae);
            chk("subword_rdata", rdata, sub_e[i]);
            chk("subword_mem_addr", mem_addr, 14'h0010);
        end

        mem[8] = 32'h11223344;
        run_op(3'd7, 14'h0021, 32'h0000_00AB, 32'h0000_0300, st, rq, ae);
        chk("sb_stall_cycles", st, 3);
        chk("sb_req_cycles", rq, 2);
        chk("sb_mem_word", mem[8], 32'h1122AB44);
        mem[8] = 32'h11223344;
        run_op(3'd6, 14'h0022, 32'h0000_CAFE, 32'h0000_0304, st, rq, ae);
        chk("sh_mem_word", mem[8], 32'hCAFE3344);

        fixed_wait = 3;
        run_op(3'd5, 14'h0008, 32'h12345678, 32'hABCD0040, st, rq, ae);
        chk("sw_stall_cycles", st, 5);
        chk("sw_req_cycles", rq, 4);
        chk("sw_mem_word", mem[2], 32'h12345678);
        chk("sw_mem_pc", mem_pc, 32'hABCD0040);

        fixed_wait = 0;
        run_op(3'd0, 14'h0006, 32'h0, 32'h0000_0400, st, rq, ae);
        chk("lw_mis_align_err", ae, 1);
        chk("lw_mis_req", rq, 0);
        chk("lw_mis_stall", st, 0);
        run_op(3'd6, 14'h0005, 32'h0, 32'h0000_0404, st, rq, ae);
        chk("sh_mis_align_err", ae, 1);
        chk("sh_mis_req", rq, 0);

        // Reset while a sb sits in its read phase.
        mem[16] = 32'h01020304;
        fixed_wait = 5;
        op_type = 3'd7; op_addr = 14'h0041; op_wdata = 32'h55; pc = 32'h500; op_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_req", mem_req, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        op_valid = 1'b0;
        fixed_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_no_write", mem[16], 32'h01020304);
        run_op(3'd0, 14'h0040, 32'h0, 32'h0000_0600, st, rq, ae);
        chk("post_rst_lw_stall", st, 2);
        chk("post_rst_lw_rdata", rdata, 32'h01020304);

        fixed_wait = -1;
        for (int n = 0; n < 300; n++) begin
            t = 3'($urandom_range(0, 7));
            a = AW'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (t == 3'd0 || t == 3'd5) a[1:0] = 2'b00;
                else if (t == 3'd1 || t == 3'd2 || t == 3'd6) a[0] = 1'b0;
            end
            run_op(t, a, $urandom, $urandom, st, rq, ae);
            if ($urandom_range(0, 2) == 0) begin
                op_type = 3'($urandom_range(0, 7));
                op_addr = AW'($urandom);
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=no finish required=finish before 1000000");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_master.md
# lsu_master

Memory-stage load/store initiator that drives the word-addressed data memory port with a req/ack handshake. It converts the M-stage memory operation (lw/lh/lhu/lb/lbu/sw/sh/sb) into word-aligned memory transactions. Sub-word stores are done as read-modify-write because the memory only writes full words. While a transaction is in flight it holds the pipeline with `stall`, then returns the lane-selected, extended load result.

## Interface
- `ADDR_W`, default 14: byte-address width of the data memory port.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  in  32  PC of the M-stage instruction, forwarded for write logging.
- `op_valid`  in  1  M stage holds a memory instruction.
- `op_type`  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- `op_addr`  in  ADDR_W  byte address.
- `op_wdata`  in  32  store data (rt value).
- `stall`  out  1  freeze pipeline stages up to and including M.
- `rdata`  out  32  extended load result, valid when `rdata_valid`.
- `rdata_valid`  out  1  one-cycle pulse, load complete.
- `align_err`  out  1  one-cycle pulse, misaligned access rejected.
- `mem_req`  out  1  transaction request.
- `mem_we`  out  1  1 = full-word write, 0 = read.
- `mem_addr`  out  ADDR_W  word-aligned byte address (bits [1:0] = 0).
- `mem_wdata`  out  32  write word.
- `mem_pc`  out  32  `pc` latched at op acceptance.
- `mem_ack`  in  1  responder completes the current request this cycle.
- `mem_rdata`  in  32  read word, valid when `mem_ack` is high and `mem_we` is 0.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE with `op_valid`:
  - Misaligned access: lw/sw with `op_addr[1:0]`≠0, or lh/lhu/sh with `op_addr[0]`≠0.
  - Misaligned: `align_err`=1 this cycle, `stall`=0, no transaction, stay IDLE.
  - sw: latch addr/data/pc, go to WR.
  - All loads, sh and sb: latch, go to RD.
- RD: `mem_req`=1, `mem_we`=0; wait for `mem_ack`.
  - On ack, load: capture the extended result and go to DONE.
  - On ack, sh/sb: build the merged word and go to WR.
- WR: `mem_req`=1, `mem_we`=1; on ack go to DONE.
- DONE: `stall`=0; `rdata_valid`=1 if the op was a load; go to IDLE next cycle.
- Byte lanes are little-endian; lane k = bits [8k+7:8k], selected by addr[1:0].
  - lb / lbu: lane byte sign- / zero-extended to 32 bits.
  - lh / lhu: half selected by addr[1] (1 → [31:16]), sign- / zero-extended.
  - sb: replace lane addr[1:0] with `op_wdata[7:0]`.
  - sh: replace the half selected by addr[1] with `op_wdata[15:0]`.
- `stall` = `op_valid` & aligned & (state≠DONE). It is combinational from state and inputs.
- Inputs are held stable by the pipeline while `stall`=1; the block does not re-sample them after acceptance.

## Timing
- Reset (sync, active-high): state IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_pc`, `rdata`, `rdata_valid` and `align_err` all 0. `stall` is forced to 0 during reset.
- Memory-side outputs are registered and stay constant from `mem_req` rise until the ack cycle inclusive.
- `mem_req` deasserts in the cycle after ack, unless RD→WR, in which case it stays 1 with `mem_we`=1 and the new data.
- An ack in the first cycle of `mem_req` is legal (zero wait). An ack while `mem_req`=0 is ignored.
- Latency with zero-wait ack, op accepted in cycle N:
  - lw/lh/lb/sw: stall in N, N+1; DONE in N+2.
  - sh/sb: stall in N..N+2; DONE in N+3.
  - Each ack wait cycle adds one stall cycle.
- `rdata` holds its value after DONE until the next load completes.
- Reset mid-transaction: the transaction is abandoned and `mem_req` drops at the next edge. No partial write is issued for an RMW that was in RD.

## Test plan
- Reset, then lw addr 0x0010 with `mem_rdata`=0xDEADBEEF and zero-wait ack → `mem_req` for 1 cycle with `mem_addr`=0x0010, `mem_we`=0; `rdata`=0xDEADBEEF with `rdata_valid` in cycle N+2; 2 stall cycles.
- lb 0x0013 / lbu 0x0013 / lh 0x0012 / lhu 0x0012 with word 0x80FF7F01 → 0xFFFFFF80 / 0x00000080 / 0xFFFF80FF / 0x000080FF; `mem_addr`=0x0010 each time.
- sb 0x0021 with data 0x000000AB and memory word 0x11223344 → a read of 0x0020, then a write of 0x1122AB44; sh 0x0022 with data 0xCAFE → write 0xCAFE3344.
- sw 0x0008 with data 0x12345678 and ack delayed 3 cycles → req/we/addr/wdata stable for 4 cycles; stall lasts 5 cycles; `mem_pc` equals the pc captured at acceptance.
- lw 0x0006, then sh 0x0005 → `align_err` pulse each, `mem_req` never asserted, `stall`=0.
- Assert reset while a sb is in RD → `mem_req`=0 at the next edge, no write issued; a following lw completes normally.
